debug_cmd_decoder: RTL and testbench

- Consumes the byte stream from the UART receiver and decodes debug-host opcodes: PING, PAUSE, RESUME, NEXT and PROGRAM.
- Drives the CPU run/pause/step controls, the breakpoint compare, and the instruction-memory reprogram port.
- Queues one-byte responses to the UART transmitter.
- Sits between the UART RX/TX and the CPU pipeline control inside the debug unit.

---
 rtl/debug_pkg.sv | 23 ++
 rtl/le_word_assembler.sv | 44 ++++
 rtl/debug_cmd_decoder.sv | 232 +++++++++++++++++++++++
 tb/tb_debug_cmd_decoder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// Shared opcodes, decoder FSM states and argument widths for the debug command decoder.
package debug_pkg;

    localparam logic [7:0] OP_SIGNAL  = 8'h01;
    localparam logic [7:0] OP_OK      = 8'h02;
    localparam logic [7:0] OP_PING    = 8'h03;
    localparam logic [7:0] OP_PAUSE   = 8'h04;
    localparam logic [7:0] OP_RESUME  = 8'h05;
    localparam logic [7:0] OP_NEXT    = 8'h06;
    localparam logic [7:0] OP_PROGRAM = 8'h07;
    localparam logic [7:0] OP_NONE    = 8'hFF;

    localparam int WORD_W    = 32;
    localparam int ARG_BYTES = WORD_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BP_ARG,
        ST_LEN_ARG,
        ST_PROG_DATA
    } dbg_state_e;

endpackage

// File: rtl/le_word_assembler.sv
// Collects bytes into little-endian 32-bit words; word_done marks the cycle the last byte arrives.
module le_word_assembler
    import debug_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              word_done,
    output logic [WORD_W-1:0] word
);

    localparam int CW = $clog2(ARG_BYTES);

    logic [CW-1:0]       cnt_q, cnt_d;
    // Only the first three bytes need storing; the fourth is taken straight from byte_data.
    logic [WORD_W-9:0]   shift_q, shift_d;

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (clear) begin
            cnt_d = '0;
        end else if (byte_valid) begin
            cnt_d   = cnt_q + 1'b1;
            shift_d = {byte_data, shift_q[WORD_W-9:8]};
        end
    end

    assign word_done = byte_valid && !clear && (cnt_q == CW'(ARG_BYTES - 1));
    assign word      = {byte_data, shift_q};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/debug_cmd_decoder.sv
// Debug-host command decoder: UART bytes in, CPU run/step/breakpoint/reprogram controls and responses out.
// Define DEBUG_ACK_EN to acknowledge every accepted command with OK.
module debug_cmd_decoder
    import debug_pkg::*;
#(
    parameter int ARG_TIMEOUT     = 2000000,
    parameter int PROG_DEPTH_LOG2 = 14,
    parameter bit START_PAUSED    = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_valid,
    input  logic [31:0]                pc,
    input  logic                       pc_valid,
    output logic                       cpu_pause,
    output logic                       step_pulse,
    output logic [31:0]                bp_addr,
    output logic                       bp_en,
    output logic [7:0]                 tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic                       prog_active,
    output logic                       prog_we,
    output logic [PROG_DEPTH_LOG2-1:0] prog_addr,
    output logic [31:0]                prog_wdata,
    output logic                       cpu_reset_req
);

`ifdef DEBUG_ACK_EN
    localparam bit ACK_EN = 1'b1;
`else
    localparam bit ACK_EN = 1'b0;
`endif

    localparam int TW = $clog2(ARG_TIMEOUT + 1);

    dbg_state_e                 state_q, state_d;
    logic [TW-1:0]              timer_q, timer_d;
    logic                       cpu_pause_q, cpu_pause_d;
    logic                       step_q, step_d;
    logic [31:0]                bp_addr_q, bp_addr_d;
    logic                       bp_en_q, bp_en_d;
    logic [7:0]                 tx_data_q, tx_data_d;
    logic                       tx_valid_q, tx_valid_d;
    logic                       prog_active_q, prog_active_d;
    logic                       prog_we_q, prog_we_d;
    logic [PROG_DEPTH_LOG2-1:0] prog_addr_q, prog_addr_d;
    logic [31:0]                prog_wdata_q, prog_wdata_d;
    logic                       reset_req_q, reset_req_d;
    logic [31:0]                len_q, len_d;
    logic [31:0]                idx_q, idx_d;

    logic                       word_done;
    logic [WORD_W-1:0]          word;
    logic                       timeout;
    logic                       bp_hit;
    logic                       resp_req;
    logic [7:0]                 resp_byte;
    logic                       tx_fire;

    le_word_assembler u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (state_q == ST_IDLE),
        .byte_valid (rx_valid),
        .byte_data  (rx_data),
        .word_done  (word_done),
        .word       (word)
    );

    assign timeout = (state_q != ST_IDLE) && !rx_valid && (timer_q == TW'(ARG_TIMEOUT - 1));
    assign bp_hit  = !cpu_pause_q && bp_en_q && pc_valid && (pc == bp_addr_q);
    assign tx_fire = tx_valid_q && tx_ready;

    always_comb begin
        state_d       = state_q;
        timer_d       = (state_q == ST_IDLE || rx_valid) ? '0 : timer_q + 1'b1;
        cpu_pause_d   = cpu_pause_q;
        step_d        = 1'b0;
        bp_addr_d     = bp_addr_q;
        bp_en_d       = bp_en_q;
        prog_active_d = prog_active_q;
        prog_we_d     = 1'b0;
        prog_addr_d   = prog_addr_q;
        prog_wdata_d  = prog_wdata_q;
        reset_req_d   = 1'b0;
        len_d         = len_q;
        idx_d         = idx_q;
        resp_req      = 1'b0;
        resp_byte     = OP_OK;

        if (timeout) begin
            state_d       = ST_IDLE;
            prog_active_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (rx_valid) begin
                        case (rx_data)
                            OP_PING: resp_req = 1'b1;
                            OP_PAUSE: begin
                                cpu_pause_d = 1'b1;
                                resp_req    = ACK_EN;
                            end
                            OP_NEXT: begin
                                if (cpu_pause_q) begin
                                    step_d   = 1'b1;
                                    resp_req = ACK_EN;
                                end
                            end
                            OP_RESUME: state_d = ST_BP_ARG;
                            OP_PROGRAM: begin
                                cpu_pause_d   = 1'b1;
                                prog_active_d = 1'b1;
                                state_d       = ST_LEN_ARG;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_BP_ARG: begin
                    if (word_done) begin
                        bp_addr_d   = word;
                        bp_en_d     = (word != '0);
                        cpu_pause_d = 1'b0;
                        resp_req    = ACK_EN;
                        state_d     = ST_IDLE;
                    end
                end
                ST_LEN_ARG: begin
                    if (word_done) begin
                        len_d = word;
                        idx_d = '0;
                        if (word == '0) begin
                            reset_req_d   = 1'b1;
                            prog_active_d = 1'b0;
                            resp_req      = ACK_EN;
                            state_d       = ST_IDLE;
                        end else begin
                            state_d = ST_PROG_DATA;
                        end
                    end
                end
                ST_PROG_DATA: begin
                    if (word_done) begin
                        // Words past the end of memory are swallowed so the host stream stays aligned.
                        if ({1'b0, idx_q} < (33'd1 << PROG_DEPTH_LOG2)) begin
                            prog_we_d    = 1'b1;
                            prog_addr_d  = idx_q[PROG_DEPTH_LOG2-1:0];
                            prog_wdata_d = word;
                        end
                        idx_d = idx_q + 32'd1;
                        if (idx_q + 32'd1 == len_q) begin
                            reset_req_d   = 1'b1;
                            prog_active_d = 1'b0;
                            resp_req      = ACK_EN;
                            state_d       = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // A hit wins over a simultaneous PAUSE or acknowledgement: one pause, one SIGNAL.
        if (bp_hit) begin
            cpu_pause_d = 1'b1;
            bp_en_d     = 1'b0;
            resp_req    = 1'b1;
            resp_byte   = OP_SIGNAL;
        end

        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        if (resp_req && (!tx_valid_q || tx_fire)) begin
            tx_valid_d = 1'b1;
            tx_data_d  = resp_byte;
        end else if (tx_fire) begin
            tx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            cpu_pause_q   <= START_PAUSED;
            step_q        <= 1'b0;
            bp_addr_q     <= '0;
            bp_en_q       <= 1'b0;
            tx_data_q     <= '0;
            tx_valid_q    <= 1'b0;
            prog_active_q <= 1'b0;
            prog_we_q     <= 1'b0;
            prog_addr_q   <= '0;
            prog_wdata_q  <= '0;
            reset_req_q   <= 1'b0;
            len_q         <= '0;
            idx_q         <= '0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            cpu_pause_q   <= cpu_pause_d;
            step_q        <= step_d;
            bp_addr_q     <= bp_addr_d;
            bp_en_q       <= bp_en_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            prog_active_q <= prog_active_d;
            prog_we_q     <= prog_we_d;
            prog_addr_q   <= prog_addr_d;
            prog_wdata_q  <= prog_wdata_d;
            reset_req_q   <= reset_req_d;
            len_q         <= len_d;
            idx_q         <= idx_d;
        end
    end

    assign cpu_pause     = cpu_pause_q;
    assign step_pulse    = step_q;
    assign bp_addr       = bp_addr_q;
    assign bp_en         = bp_en_q;
    assign tx_data       = tx_data_q;
    assign tx_valid      = tx_valid_q;
    assign prog_active   = prog_active_q;
    assign prog_we       = prog_we_q;
    assign prog_addr     = prog_addr_q;
    assign prog_wdata    = prog_wdata_q;
    assign cpu_reset_req = reset_req_q;

endmodule

// File: tb/tb_debug_cmd_decoder.sv
// Directed bench for debug_cmd_decoder with a short timeout and a 4-word program memory.
module tb_debug_cmd_decoder;

`ifdef DEBUG_ACK_EN
    localparam int ACK = 1;
`else
    localparam int ACK = 0;
`endif
    localparam int TO  = 40;
    localparam int PDL = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [7:0]     rx_data;
    logic           rx_valid;
    logic [31:0]    pc;
    logic           pc_valid;
    logic           cpu_pause;
    logic           step_pulse;
    logic [31:0]    bp_addr;
    logic           bp_en;
    logic [7:0]     tx_data;
    logic           tx_valid;
    logic           tx_ready;
    logic           prog_active;
    logic           prog_we;
    logic [PDL-1:0] prog_addr;
    logic [31:0]    prog_wdata;
    logic           cpu_reset_req;

    int checks = 0;
    int failures = 0;
    int step_cnt = 0;
    int reset_cnt = 0;
    int tx_cnt = 0;
    int wr_cnt = 0;
    logic [7:0]  tx_last = '0;
    logic [31:0] wr_addr [16];
    logic [31:0] wr_data [16];
    int base;

    always #5 clk = ~clk;

    debug_cmd_decoder #(
        .ARG_TIMEOUT     (TO),
        .PROG_DEPTH_LOG2 (PDL),
        .START_PAUSED    (1'b1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .pc            (pc),
        .pc_valid      (pc_valid),
        .cpu_pause     (cpu_pause),
        .step_pulse    (step_pulse),
        .bp_addr       (bp_addr),
        .bp_en         (bp_en),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .prog_active   (prog_active),
        .prog_we       (prog_we),
        .prog_addr     (prog_addr),
        .prog_wdata    (prog_wdata),
        .cpu_reset_req (cpu_reset_req)
    );

    always @(negedge clk) begin
        if (rst_n) begin
            if (step_pulse) step_cnt++;
            if (cpu_reset_req) reset_cnt++;
            if (prog_we && wr_cnt < 16) begin
                wr_addr[wr_cnt] = 32'(prog_addr);
                wr_data[wr_cnt] = prog_wdata;
                wr_cnt++;
            end
            if (tx_valid && tx_ready) begin
                tx_last = tx_data;
                tx_cnt++;
                $display("tx byte 0x%02h", tx_data);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic pc_commit(input logic [31:0] a);
        @(posedge clk);
        #1;
        pc       = a;
        pc_valid = 1'b1;
        @(posedge clk);
        #1;
        pc_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; rx_data = '0; rx_valid = 1'b0;
        pc = '0; pc_valid = 1'b0; tx_ready = 1'b1;
        idle(3);
        rst_n = 1'b1;
        #1;
        check("rst_pause", 32'(cpu_pause), 32'd1);
        check("rst_bp_en", 32'(bp_en), 32'd0);
        check("rst_bp_addr", bp_addr, 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_prog_active", 32'(prog_active), 32'd0);

        // PING
        send_byte(8'h03);
        idle(3);
        check("ping_cnt", 32'(tx_cnt), 32'd1);
        check("ping_byte", 32'(tx_last), 32'h02);
        check("ping_pause", 32'(cpu_pause), 32'd1);

        // RESUME with breakpoint 4, then hit
        base = tx_cnt;
        send_byte(8'h05);
        send_word(32'h0000_0004);
        check("bp_addr", bp_addr, 32'd4);
        check("bp_en", 32'(bp_en), 32'd1);
        check("resume_pause", 32'(cpu_pause), 32'd0);
        pc_commit(32'd8);
        check("miss_pause", 32'(cpu_pause), 32'd0);
        pc_commit(32'd4);
        check("hit_pause", 32'(cpu_pause), 32'd1);
        check("hit_bp_en", 32'(bp_en), 32'd0);
        idle(3);
        check("hit_tx_cnt", 32'(tx_cnt - base), 32'(ACK + 1));
        check("hit_tx_byte", 32'(tx_last), 32'h01);

        // NEXT while paused, then while running
        send_byte(8'h06);
        send_byte(8'h06);
        idle(2);
        check("step_paused", 32'(step_cnt), 32'd2);
        send_byte(8'h05);
        send_word(32'h0);
        check("bp0_en", 32'(bp_en), 32'd0);
        check("bp0_pause", 32'(cpu_pause), 32'd0);
        send_byte(8'h06);
        idle(2);
        check("step_running", 32'(step_cnt), 32'd2);
        pc_commit(32'd0);
        check("bp0_nohit", 32'(cpu_pause), 32'd0);

        // PROGRAM two words
        send_byte(8'h07);
        check("prog_pause", 32'(cpu_pause), 32'd1);
        check("prog_active_on", 32'(prog_active), 32'd1);
        send_word(32'd2);
        send_word(32'h0000_0013);
        send_word(32'h0011_2233);
        idle(2);
        check("prog_wr_cnt", 32'(wr_cnt), 32'd2);
        check("prog_addr0", wr_addr[0], 32'd0);
        check("prog_data0", wr_data[0], 32'h0000_0013);
        check("prog_addr1", wr_addr[1], 32'd1);
        check("prog_data1", wr_data[1], 32'h0011_2233);
        check("prog_reset_req", 32'(reset_cnt), 32'd1);
        check("prog_active_off", 32'(prog_active), 32'd0);
        check("prog_pause_kept", 32'(cpu_pause), 32'd1);

        // PROGRAM five words into 4-word memory; opcode bytes inside data
        base = tx_cnt;
        send_byte(8'h07);
        send_word(32'd5);
        for (int k = 0; k < 5; k++) send_word(32'h0506_0700 | 32'(k + 3));
        idle(3);
        check("ovf_wr_cnt", 32'(wr_cnt), 32'd6);
        check("ovf_first", wr_data[2], 32'h0506_0703);
        check("ovf_last_addr", wr_addr[5], 32'd3);
        check("ovf_last_data", wr_data[5], 32'h0506_0706);
        check("ovf_reset_req", 32'(reset_cnt), 32'd2);
        check("ovf_no_decode_tx", 32'(tx_cnt - base), 32'(ACK));
        check("ovf_no_step", 32'(step_cnt), 32'd2);

        // PROGRAM with N=0
        send_byte(8'h07);
        send_word(32'd0);
        idle(2);
        check("n0_reset_req", 32'(reset_cnt), 32'd3);
        check("n0_active", 32'(prog_active), 32'd0);
        check("n0_wr_cnt", 32'(wr_cnt), 32'd6);

        // Breakpoint argument timeout
        send_byte(8'h05);
        send_word(32'h0000_0100);
        send_byte(8'h04);
        check("to_setup_en", 32'(bp_en), 32'd1);
        idle(2);
        base = tx_cnt;
        send_byte(8'h05);
        send_byte(8'h04);
        idle(TO + 5);
        send_byte(8'h03);
        idle(3);
        check("to_bp_en", 32'(bp_en), 32'd1);
        check("to_bp_addr", bp_addr, 32'h0000_0100);
        check("to_pause", 32'(cpu_pause), 32'd1);
        check("to_ping_cnt", 32'(tx_cnt - base), 32'd1);
        check("to_ping_byte", 32'(tx_last), 32'h02);

        // Program length timeout
        send_byte(8'h07);
        send_byte(8'h01);
        send_byte(8'h00);
        idle(TO + 5);
        check("to_prog_active", 32'(prog_active), 32'd0);
        check("to_prog_noreset", 32'(reset_cnt), 32'd3);

        // Backpressure: second PING dropped
        base = tx_cnt;
        tx_ready = 1'b0;
        send_byte(8'h03);
        send_byte(8'h03);
        idle(3);
        check("bp_hold_cnt", 32'(tx_cnt - base), 32'd0);
        check("bp_hold_valid", 32'(tx_valid), 32'd1);
        check("bp_hold_data", 32'(tx_data), 32'h02);
        tx_ready = 1'b1;
        idle(4);
        check("bp_single_ok", 32'(tx_cnt - base), 32'd1);

        // PAUSE acknowledgement depends on build option
        base = tx_cnt;
        send_byte(8'h04);
        idle(3);
        check("pause_ack", 32'(tx_cnt - base), 32'(ACK));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
